// File: rtl/seq_decoder_pkg.sv
// Shared types for the sequenced 3-to-8 one-hot decoder.
// Holds the FIFO entry layout, FSM states and the strobe decode.
package seq_decoder_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } dec_state_t;

  typedef struct packed {
    logic              en;
    logic [CODE_W-1:0] code;
  } dec_entry_t;

  function automatic logic [OUT_W-1:0] decode(
    input dec_entry_t e
  );
    logic [OUT_W-1:0] y;
    y = '0;
    if (e.en) y[e.code] = 1'b1;
    return y;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// Synchronous FIFO of decoder entries with an occupancy counter.
// Read data is the head entry, valid whenever empty is low.
module code_fifo
  import seq_decoder_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  dec_entry_t din,
  output dec_entry_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  dec_entry_t      mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [AW:0]     count;

  assign dout  = mem[rptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wptr] <= din;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/seq_decoder_3to8.sv
// Sequenced 3-to-8 decoder: queues {en, code} entries and replays
// each as a timed one-hot strobe followed by a forced idle gap.
module seq_decoder_3to8
  import seq_decoder_pkg::*;
#(
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 1,
  parameter int DEPTH     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  input  logic              en,
  output logic              code_ready,
  output logic [OUT_W-1:0]  Y,
  output logic              y_valid,
  output logic              busy
);

  localparam int MAX_LEN =
    (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CNT_W =
    (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam bit HAS_GAP = (GAP_LEN > 0);
  localparam logic [CNT_W-1:0] PULSE_LD =
    CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD =
    CNT_W'(HAS_GAP ? GAP_LEN - 1 : 0);

  dec_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  dec_entry_t       head;
  dec_entry_t       din;

  assign din        = '{en: en, code: code};
  assign code_ready = ~full & ~rst;
  assign push       = code_valid & code_ready;
  assign busy       = (state != IDLE) | ~empty;

  code_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (din),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  // Pop exactly where the FSM below starts a new strobe.
  always_comb begin
    pop = 1'b0;
    if (!rst && !empty) begin
      unique case (state)
        IDLE:    pop = 1'b1;
        PULSE:   pop = (cnt == '0) && !HAS_GAP;
        GAP:     pop = (cnt == '0);
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      Y       <= '0;
      y_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state   <= PULSE;
            cnt     <= PULSE_LD;
            Y       <= decode(head);
            y_valid <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (HAS_GAP) begin
            state   <= GAP;
            cnt     <= GAP_LD;
            Y       <= '0;
            y_valid <= 1'b0;
          end else if (!empty) begin
            cnt <= PULSE_LD;
            Y   <= decode(head);
          end else begin
            state   <= IDLE;
            Y       <= '0;
            y_valid <= 1'b0;
          end
        end
        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!empty) begin
            state   <= PULSE;
            cnt     <= PULSE_LD;
            Y       <= decode(head);
            y_valid <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_decoder_3to8.sv
// Bench for seq_decoder_3to8: directed scenarios plus random traffic
// against a strobe-schedule model (each entry gets a start cycle).
module tb_seq_decoder_3to8;
  import seq_decoder_pkg::*;

  localparam int P = 2;
  localparam int G = 1;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cv = 1'b0;
  logic [2:0] code = 3'd0;
  logic       en = 1'b0;
  logic       rdy;
  logic [7:0] Y;
  logic       yv;
  logic       busy;

  logic       cv0 = 1'b0;
  logic [2:0] code0 = 3'd0;
  logic       en0 = 1'b0;
  logic       rdy0;
  logic [7:0] y0;
  logic       yv0;
  logic       busy0;

  int checks = 0;
  int failures = 0;

  int         n = 0;
  int         next_start = 0;
  int         st_q[$];
  logic [3:0] ent_q[$];

  always #5 clk = ~clk;

  seq_decoder_3to8 #(
    .PULSE_LEN(P), .GAP_LEN(G), .DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .code_valid(cv),
    .code(code), .en(en), .code_ready(rdy),
    .Y(Y), .y_valid(yv), .busy(busy)
  );

  seq_decoder_3to8 #(
    .PULSE_LEN(1), .GAP_LEN(0), .DEPTH(2)
  ) dut0 (
    .clk(clk), .rst(rst), .code_valid(cv0),
    .code(code0), .en(en0), .code_ready(rdy0),
    .Y(y0), .y_valid(yv0), .busy(busy0)
  );

  // Entries waiting in the queue: accepted but not yet started.
  function automatic int occ();
    int k;
    k = 0;
    foreach (st_q[i]) if (st_q[i] > n) k++;
    return k;
  endfunction

  // Expected {Y, y_valid, busy, code_ready} after edge n.
  function automatic logic [10:0] exp_out();
    logic [7:0] y;
    logic       v;
    logic       b;
    logic [3:0] e;
    y = 8'h00;
    v = 1'b0;
    b = (occ() > 0);
    foreach (st_q[i]) begin
      if (st_q[i] <= n && n < st_q[i] + P) begin
        e = ent_q[i];
        v = 1'b1;
        y = e[3] ? 8'(2 ** int'(e[2:0])) : 8'h00;
      end
      if (st_q[i] <= n && n < st_q[i] + P + G) b = 1'b1;
    end
    return {y, v, b, !rst && occ() < D};
  endfunction

  task automatic tick(
    input  logic       v,
    input  logic [2:0] c,
    input  logic       e,
    input  logic       r,
    output logic       acc
  );
    int s;
    @(negedge clk);
    cv = v; code = c; en = e; rst = r;
    acc = v && !r && (occ() < D);
    @(posedge clk);
    n++;
    if (r) begin
      st_q.delete();
      ent_q.delete();
      next_start = 0;
    end else if (acc) begin
      s = (n + 1 > next_start) ? n + 1 : next_start;
      st_q.push_back(s);
      ent_q.push_back({e, c});
      next_start = s + P + G;
    end
    #1;
  endtask

  task automatic test_reset();
    logic a;
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 3'd4, 1'b1, 1'b1, a);
      checks++;
      if ({Y, yv, busy, rdy} !== 11'h0) begin
        failures++;
        $display("FAIL reset got=%h exp=000",
                 {Y, yv, busy, rdy});
      end
    end
    tick(1'b0, 3'd0, 1'b0, 1'b0, a);
    checks++;
    if ({Y, yv, busy, rdy} !== 11'h001) begin
      failures++;
      $display("FAIL reset_release got=%h exp=001",
               {Y, yv, busy, rdy});
    end
  endtask

  task automatic test_single();
    logic a;
    logic [10:0] tbl [6];
    tbl = '{{8'h20, 3'b111}, {8'h20, 3'b111},
            {8'h00, 3'b011}, {8'h00, 3'b001},
            {8'h00, 3'b001}, {8'h00, 3'b001}};
    tick(1'b1, 3'd5, 1'b1, 1'b0, a);
    checks++;
    if ({Y, yv, busy, rdy} !== {8'h00, 3'b011}) begin
      failures++;
      $display("FAIL single_push got=%h exp=%h",
               {Y, yv, busy, rdy}, {8'h00, 3'b011});
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 3'd0, 1'b0, 1'b0, a);
      checks++;
      if ({Y, yv, busy, rdy} !== tbl[i]) begin
        failures++;
        $display("FAIL single c%0d got=%h exp=%h",
                 i, {Y, yv, busy, rdy}, tbl[i]);
      end
    end
  endtask

  task automatic test_disabled();
    logic a;
    logic [10:0] tbl [5];
    tbl = '{{8'h00, 3'b111}, {8'h00, 3'b111},
            {8'h00, 3'b011}, {8'h00, 3'b001},
            {8'h00, 3'b001}};
    tick(1'b1, 3'd3, 1'b0, 1'b0, a);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 3'd0, 1'b0, 1'b0, a);
      checks++;
      if ({Y, yv, busy, rdy} !== tbl[i]) begin
        failures++;
        $display("FAIL disabled c%0d got=%h exp=%h",
                 i, {Y, yv, busy, rdy}, tbl[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       a;
    logic       saw_low;
    logic       prev_v;
    logic [2:0] codes [3];
    logic [7:0] seen[$];
    int         idx;
    codes   = '{3'd0, 3'd7, 3'd2};
    idx     = 0;
    saw_low = 1'b0;
    prev_v  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(idx < 3, (idx < 3) ? codes[idx] : 3'd0,
           1'b1, 1'b0, a);
      if (a) idx++;
      if (!rdy) saw_low = 1'b1;
      if (yv && !prev_v) seen.push_back(Y);
      prev_v = yv;
      checks++;
      if ({Y, yv, busy, rdy} !== exp_out()) begin
        failures++;
        $display("FAIL b2b c%0d got=%h exp=%h",
                 i, {Y, yv, busy, rdy}, exp_out());
      end
    end
    checks++;
    if (!saw_low) begin
      failures++;
      $display("FAIL b2b_backpressure got=0 exp=1");
    end
    checks++;
    if (seen.size() != 3 ||
        seen[0] !== 8'h01 || seen[1] !== 8'h80 ||
        seen[2] !== 8'h04) begin
      failures++;
      $display("FAIL b2b_seq got=%p exp=01,80,04", seen);
    end
  endtask

  task automatic test_gap0();
    logic a;
    logic [9:0] tbl [3];
    tbl = '{{8'h02, 2'b11}, {8'h40, 2'b11},
            {8'h00, 2'b00}};
    cv0 = 1'b1; code0 = 3'd1; en0 = 1'b1;
    tick(1'b0, 3'd0, 1'b0, 1'b0, a);
    code0 = 3'd6;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 3'd0, 1'b0, 1'b0, a);
      cv0 = 1'b0;
      checks++;
      if ({y0, yv0, busy0} !== tbl[i]) begin
        failures++;
        $display("FAIL gap0 c%0d got=%h exp=%h",
                 i, {y0, yv0, busy0}, tbl[i]);
      end
    end
  endtask

  task automatic test_full();
    logic a;
    int   acc_n;
    acc_n = 0;
    for (int i = 0; i < 30; i++) begin
      tick(i < 14, 3'($urandom), 1'($urandom), 1'b0, a);
      if (a) acc_n++;
      checks++;
      if ({Y, yv, busy, rdy} !== exp_out()) begin
        failures++;
        $display("FAIL full c%0d got=%h exp=%h",
                 i, {Y, yv, busy, rdy}, exp_out());
      end
    end
    checks++;
    if (acc_n > 7) begin
      failures++;
      $display("FAIL full_accepts got=%0d exp<=7", acc_n);
    end
  endtask

  task automatic test_reset_mid();
    logic a;
    tick(1'b1, 3'd6, 1'b1, 1'b0, a);
    tick(1'b1, 3'd1, 1'b1, 1'b0, a);
    tick(1'b0, 3'd0, 1'b0, 1'b0, a);
    tick(1'b0, 3'd0, 1'b0, 1'b1, a);
    checks++;
    if ({Y, yv, busy, rdy} !== 11'h0) begin
      failures++;
      $display("FAIL rst_mid got=%h exp=000",
               {Y, yv, busy, rdy});
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 3'd0, 1'b0, 1'b0, a);
      checks++;
      if ({Y, yv, busy, rdy} !== 11'h001) begin
        failures++;
        $display("FAIL rst_mid_after c%0d got=%h exp=001",
                 i, {Y, yv, busy, rdy});
      end
    end
  endtask

  task automatic test_random();
    logic a;
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), 3'($urandom),
           1'($urandom), $urandom_range(0, 63) == 0, a);
      checks++;
      if ({Y, yv, busy, rdy} !== exp_out()) begin
        failures++;
        $display("FAIL random c%0d got=%h exp=%h",
                 i, {Y, yv, busy, rdy}, exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_disabled();
    test_back_to_back();
    test_gap0();
    test_full();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
